instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/cpu24_pkg.sv | 42 ++++
 rtl/instr_fetch.sv | 189 ++++++++++++++++++
 tb/tb_instr_fetch.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu24_pkg.sv
// -----------------------------------------------------------------------------
// cpu24_pkg
// Shared definitions for the 24-bit CPU slice: datapath widths, opcode
// constants, the instruction-fetch state encoding and a small address helper.
//
// Configuration macro: IFETCH_HALT_EN adds the HALTED fetch state.
// -----------------------------------------------------------------------------
package cpu24_pkg;

  localparam int INSTR_W = 24;
  localparam int ADDR_W  = 16;

  // Opcode field values (Instr[23:20])
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_LS    = 4'b0010;
  localparam logic [3:0] OP_SS    = 4'b0011;
  localparam logic [3:0] OP_BEQ   = 4'b0100;
  localparam logic [3:0] OP_RTYPE = 4'b0110;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  // Fetch FSM states; FETCHk requests byte k of the instruction at PC.
  typedef enum logic [2:0] {
    FETCH0 = 3'd0,
    FETCH1 = 3'd1,
    FETCH2 = 3'd2,
    HOLD   = 3'd3
`ifdef IFETCH_HALT_EN
    ,
    HALTED = 3'd4
`endif
  } fetchState_e;

  // Byte address of byte 'idx' of the instruction starting at 'base';
  // wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] fetchAddr(
    input logic [ADDR_W-1:0] base,
    input logic [1:0]        idx
  );
    return base + {{(ADDR_W-2){1'b0}}, idx};
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Byte-serial instruction fetch for 24-bit instructions. Three byte reads
// (big-endian) are assembled into Instr, which is then held and offered to
// decode until accepted. On acceptance the PC advances by 3 or is redirected
// to branch_target.
//
// Ports:
//   Clock          - single clock, rising edge
//   Reset          - asynchronous, active-high reset
//   mem_req        - byte-read request (registered)
//   mem_addr[15:0] - byte address of the current request (registered)
//   mem_rdata[7:0] - read data, valid with mem_ack
//   mem_ack        - one-cycle completion strobe; may arrive in the same
//                    cycle mem_req first rises
//   Instr[23:0]    - last fully assembled instruction
//   OPCODE[3:0]    - Instr[23:20]
//   Funct[3:0]     - Instr[3:0]
//   PC[15:0]       - address of the instruction being fetched or held
//   instr_valid    - Instr offered to decode
//   instr_ready    - decode accepts Instr this cycle
//   br_taken       - redirect request, sampled only on handshake
//   branch_target  - redirect address
//   halted         - fetch stopped by HALT (IFETCH_HALT_EN only)
//
// Configuration macro: IFETCH_HALT_EN -- accepting an OP_HALT instruction
// stops fetching until Reset.
//
// All outputs are registered from the next-state logic, so mem_req rises one
// clock after Reset deasserts and instr_valid rises on the 4th edge with a
// zero-wait memory; steady-state throughput is one instruction per 4 cycles.
// -----------------------------------------------------------------------------
module instr_fetch
  import cpu24_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               Clock,
  input  logic               Reset,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [7:0]         mem_rdata,
  input  logic               mem_ack,
  output logic [INSTR_W-1:0] Instr,
  output logic [3:0]         OPCODE,
  output logic [3:0]         Funct,
  output logic [ADDR_W-1:0]  PC,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  branch_target
`ifdef IFETCH_HALT_EN
  ,
  output logic               halted
`endif
);

  fetchState_e        state_r;
  fetchState_e        nextState_s;
  logic [ADDR_W-1:0]  nextPc_s;
  logic [ADDR_W-1:0]  addrNext_s;
  logic               reqNext_s;
  logic               ackTaken_s;
  logic               handshake_s;
  logic [7:0]         byteHi_r;
  logic [7:0]         byteMid_r;

  // An ack only counts while a request is actually outstanding, which also
  // masks it in HOLD/HALTED and in the idle cycle right after reset.
  assign ackTaken_s  = mem_req & mem_ack;
  assign handshake_s = (state_r == HOLD) & instr_valid & instr_ready;

  assign OPCODE = Instr[23:20];
  assign Funct  = Instr[3:0];

  // Next-state and next-PC logic of the fetch FSM
  always_comb begin
    nextState_s = state_r;
    nextPc_s    = PC;
    case (state_r)
      FETCH0: begin
        if (ackTaken_s) nextState_s = FETCH1;
        else            nextState_s = FETCH0;
      end
      FETCH1: begin
        if (ackTaken_s) nextState_s = FETCH2;
        else            nextState_s = FETCH1;
      end
      FETCH2: begin
        if (ackTaken_s) nextState_s = HOLD;
        else            nextState_s = FETCH2;
      end
      HOLD: begin
        if (handshake_s) begin
`ifdef IFETCH_HALT_EN
          if (OPCODE == OP_HALT) begin
            nextState_s = HALTED;
            nextPc_s    = PC;
          end else begin
            nextState_s = FETCH0;
            nextPc_s    = br_taken ? branch_target : fetchAddr(PC, 2'd3);
          end
`else
          nextState_s = FETCH0;
          nextPc_s    = br_taken ? branch_target : fetchAddr(PC, 2'd3);
`endif
        end else begin
          nextState_s = HOLD;
        end
      end
`ifdef IFETCH_HALT_EN
      HALTED: begin
        nextState_s = HALTED;
      end
`endif
      default: begin
        nextState_s = FETCH0;
      end
    endcase
  end

  // Request and address that go with the next state; the address is held
  // while no request is outstanding.
  always_comb begin
    reqNext_s  = 1'b0;
    addrNext_s = mem_addr;
    case (nextState_s)
      FETCH0: begin
        reqNext_s  = 1'b1;
        addrNext_s = fetchAddr(nextPc_s, 2'd0);
      end
      FETCH1: begin
        reqNext_s  = 1'b1;
        addrNext_s = fetchAddr(nextPc_s, 2'd1);
      end
      FETCH2: begin
        reqNext_s  = 1'b1;
        addrNext_s = fetchAddr(nextPc_s, 2'd2);
      end
      default: begin
        reqNext_s  = 1'b0;
        addrNext_s = mem_addr;
      end
    endcase
  end

  // FSM state, PC and registered control outputs
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r     <= FETCH0;
      PC          <= RESET_PC;
      mem_req     <= 1'b0;
      mem_addr    <= RESET_PC;
      instr_valid <= 1'b0;
`ifdef IFETCH_HALT_EN
      halted      <= 1'b0;
`endif
    end else begin
      state_r     <= nextState_s;
      PC          <= nextPc_s;
      mem_req     <= reqNext_s;
      mem_addr    <= addrNext_s;
      instr_valid <= (nextState_s == HOLD);
`ifdef IFETCH_HALT_EN
      halted      <= (nextState_s == HALTED);
`endif
    end
  end

  // Byte buffer and instruction assembly; Instr changes only on the last
  // byte so decode never sees a partially fetched instruction.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      byteHi_r  <= 8'h00;
      byteMid_r <= 8'h00;
      Instr     <= {INSTR_W{1'b0}};
    end else if (ackTaken_s) begin
      case (state_r)
        FETCH0:  byteHi_r  <= mem_rdata;
        FETCH1:  byteMid_r <= mem_rdata;
        FETCH2:  Instr     <= {byteHi_r, byteMid_r, mem_rdata};
        default: byteHi_r  <= byteHi_r;
      endcase
    end else begin
      byteHi_r <= byteHi_r;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Directed bench for instr_fetch. A behavioural byte memory with a
// programmable ack delay serves the main instance (RESET_PC=0); a second
// instance with RESET_PC=16'hFFFE and a zero-wait memory covers address wrap
// and reset in the middle of a fetch.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  logic        Clock = 1'b0;
  always #5 Clock = ~Clock;

  // main instance
  logic        Reset;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic [23:0] Instr;
  logic [3:0]  OPCODE;
  logic [3:0]  Funct;
  logic [15:0] PC;
  logic        instr_valid;
  logic        instr_ready;
  logic        br_taken;
  logic [15:0] branch_target;

  // wrap-test instance
  logic        reset2;
  logic        memReq2;
  logic [15:0] memAddr2;
  logic [7:0]  memRdata2;
  logic        memAck2;
  logic [23:0] instr2;
  logic [3:0]  opcode2;
  logic [3:0]  funct2;
  logic [15:0] pc2;
  logic        valid2;
  logic        ready2;
  logic        brTaken2 = 1'b0;
  logic [15:0] target2  = 16'h0000;

`ifdef IFETCH_HALT_EN
  logic        halted;
  logic        halted2;
`endif

  int totalCnt = 0;
  int badCnt   = 0;
  int ackDelay = 0;
  int waitCnt  = 0;
  int n;

  instr_fetch dut (
    .Clock(Clock), .Reset(Reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .Instr(Instr), .OPCODE(OPCODE), .Funct(Funct), .PC(PC),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .br_taken(br_taken), .branch_target(branch_target)
`ifdef IFETCH_HALT_EN
    , .halted(halted)
`endif
  );

  instr_fetch #(.RESET_PC(16'hFFFE)) dut2 (
    .Clock(Clock), .Reset(reset2),
    .mem_req(memReq2), .mem_addr(memAddr2), .mem_rdata(memRdata2), .mem_ack(memAck2),
    .Instr(instr2), .OPCODE(opcode2), .Funct(funct2), .PC(pc2),
    .instr_valid(valid2), .instr_ready(ready2),
    .br_taken(brTaken2), .branch_target(target2)
`ifdef IFETCH_HALT_EN
    , .halted(halted2)
`endif
  );

  // Instruction memory contents
  function automatic logic [7:0] memByte(input logic [15:0] a);
    case (a)
      16'h0000: memByte = 8'h61;
      16'h0001: memByte = 8'h23;
      16'h0002: memByte = 8'h45;
      16'h0003: memByte = 8'hA1;
      16'h0004: memByte = 8'hB2;
      16'h0005: memByte = 8'hC3;
      16'h0100: memByte = 8'h7C;
      16'h0101: memByte = 8'hDE;
      16'h0102: memByte = 8'h9F;
      16'h0103: memByte = 8'hF0;
      16'h0104: memByte = 8'h00;
      16'h0105: memByte = 8'h00;
      16'hFFFE: memByte = 8'h12;
      16'hFFFF: memByte = 8'h34;
      default:  memByte = 8'h00;
    endcase
  endfunction

  // Memory model: ack after ackDelay wait cycles of an outstanding request
  always @(posedge Clock) begin
    if (!mem_req || mem_ack) waitCnt <= 0;
    else                     waitCnt <= waitCnt + 1;
  end
  assign mem_ack   = mem_req && (waitCnt == ackDelay);
  assign mem_rdata = memByte(mem_addr);
  assign memAck2   = memReq2;
  assign memRdata2 = memByte(memAddr2);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalCnt++;
    if (got !== exp) begin
      badCnt++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // one rising edge, then sample on the following falling edge
  task automatic step();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  initial begin
    Reset = 1'b1; reset2 = 1'b1; ready2 = 1'b0;
    instr_ready = 1'b0; br_taken = 1'b0; branch_target = 16'h0000;
    repeat (2) @(negedge Clock);
    chk("rst_req",   {31'd0, mem_req},     32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", {8'd0, Instr},        32'd0);
    chk("rst_pc",    {16'd0, PC},          32'd0);

    // zero-wait fetch of 0x612345
    Reset = 1'b0;
    step();
    chk("e1_req",   {31'd0, mem_req},     32'd1);
    chk("e1_addr",  {16'd0, mem_addr},    32'h0000);
    chk("e1_valid", {31'd0, instr_valid}, 32'd0);
    step();
    chk("e2_addr",  {16'd0, mem_addr},    32'h0001);
    step();
    chk("e3_addr",  {16'd0, mem_addr},    32'h0002);
    chk("e3_valid", {31'd0, instr_valid}, 32'd0);
    step();
    chk("e4_valid", {31'd0, instr_valid}, 32'd1);
    chk("e4_instr", {8'd0, Instr},        32'h612345);
    chk("e4_op",    {28'd0, OPCODE},      32'd6);
    chk("e4_funct", {28'd0, Funct},       32'd5);
    chk("e4_req",   {31'd0, mem_req},     32'd0);
    chk("e4_pc",    {16'd0, PC},          32'h0000);

    // decode stall with a br_taken pulse that must be ignored
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin br_taken = 1'b1; branch_target = 16'h0200; end
      if (i == 3) begin br_taken = 1'b0; branch_target = 16'h0000; end
      step();
      chk("stall_instr", {8'd0, Instr},        32'h612345);
      chk("stall_req",   {31'd0, mem_req},     32'd0);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_pc",    {16'd0, PC},          32'h0000);
    end

    // sequential handshake, next fetch with 2-cycle ack delay per byte
    ackDelay = 2;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("hs_pc",    {16'd0, PC},          32'h0003);
    chk("hs_addr",  {16'd0, mem_addr},    32'h0003);
    chk("hs_req",   {31'd0, mem_req},     32'd1);
    chk("hs_valid", {31'd0, instr_valid}, 32'd0);
    br_taken = 1'b1; branch_target = 16'h0200;
    step();
    chk("wait1_addr", {16'd0, mem_addr}, 32'h0003);
    chk("wait1_req",  {31'd0, mem_req},  32'd1);
    step();
    chk("wait2_addr", {16'd0, mem_addr}, 32'h0003);
    chk("wait2_req",  {31'd0, mem_req},  32'd1);
    br_taken = 1'b0; branch_target = 16'h0000;
    n = 2;
    while (!instr_valid && n < 40) begin
      step();
      n++;
    end
    chk("dly_latency", n,              32'd9);
    chk("dly_instr",   {8'd0, Instr},  32'hA1B2C3);
    chk("dly_pc",      {16'd0, PC},    32'h0003);

    // taken branch on handshake
    ackDelay = 0;
    br_taken = 1'b1; branch_target = 16'h0100; instr_ready = 1'b1;
    step();
    br_taken = 1'b0; branch_target = 16'h0000; instr_ready = 1'b0;
    chk("br_addr", {16'd0, mem_addr}, 32'h0100);
    chk("br_pc",   {16'd0, PC},       32'h0100);
    repeat (3) step();
    chk("br_valid", {31'd0, instr_valid}, 32'd1);
    chk("br_instr", {8'd0, Instr},        32'h7CDE9F);
    chk("br_op",    {28'd0, OPCODE},      32'd7);
    chk("br_funct", {28'd0, Funct},       32'hF);

    // fetch of the HALT-opcode instruction
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("seq_pc",   {16'd0, PC},       32'h0103);
    chk("seq_addr", {16'd0, mem_addr}, 32'h0103);
    repeat (3) step();
    chk("halt_instr", {8'd0, Instr},   32'hF00000);
    chk("halt_op",    {28'd0, OPCODE}, 32'hF);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
`ifdef IFETCH_HALT_EN
    chk("halt_flag", {31'd0, halted},  32'd1);
    chk("halt_req",  {31'd0, mem_req}, 32'd0);
    chk("halt_pc",   {16'd0, PC},      32'h0103);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("halted_req",   {31'd0, mem_req},     32'd0);
      chk("halted_flag",  {31'd0, halted},      32'd1);
      chk("halted_valid", {31'd0, instr_valid}, 32'd0);
    end
`else
    chk("nohalt_pc",   {16'd0, PC},       32'h0106);
    chk("nohalt_addr", {16'd0, mem_addr}, 32'h0106);
    chk("nohalt_req",  {31'd0, mem_req},  32'd1);
`endif

    // RESET_PC=FFFE: address wrap, then reset mid-fetch
    reset2 = 1'b0;
    step();
    chk("w_addr0", {16'd0, memAddr2}, 32'hFFFE);
    chk("w_req0",  {31'd0, memReq2},  32'd1);
    step();
    chk("w_addr1", {16'd0, memAddr2}, 32'hFFFF);
    step();
    chk("w_addr2", {16'd0, memAddr2}, 32'h0000);
    step();
    chk("w_valid", {31'd0, valid2},   32'd1);
    chk("w_instr", {8'd0, instr2},    32'h123461);
    chk("w_pc",    {16'd0, pc2},      32'hFFFE);
    ready2 = 1'b1;
    step();
    ready2 = 1'b0;
    chk("w_nextpc",   {16'd0, pc2},      32'h0001);
    chk("w_nextaddr", {16'd0, memAddr2}, 32'h0001);
    step();
    chk("w_byte1addr", {16'd0, memAddr2}, 32'h0002);
    reset2 = 1'b1;
    #1;
    chk("mid_rst_req",   {31'd0, memReq2}, 32'd0);
    chk("mid_rst_pc",    {16'd0, pc2},     32'hFFFE);
    chk("mid_rst_valid", {31'd0, valid2},  32'd0);
    chk("mid_rst_instr", {8'd0, instr2},   32'd0);
    @(negedge Clock);
    reset2 = 1'b0;
    step();
    chk("restart_addr", {16'd0, memAddr2}, 32'hFFFE);
    chk("restart_req",  {31'd0, memReq2},  32'd1);

    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end

endmodule
